// File: rtl/vector_reduce_pkg.sv
// Shared state encoding and default parameters for vector_reduce, its integration top and its bench.
package vector_reduce_pkg;

  typedef enum logic [0:0] {
    S_ACC   = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_VECTOR_SIZE = 64;
  localparam int DEF_CNT_WIDTH   = 16;

endpackage

// File: rtl/vector_reduce.sv
// Sums VECTOR_SIZE popped elements into one scalar; result write is offered the cycle after the last pop.
// Stalls on upstream empty or result full; `VECTOR_REDUCE_SAT_EN` selects saturating accumulation with sticky overflow.
module vector_reduce
  import vector_reduce_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [CNT_WIDTH-1:0]  vec_count,
  output logic                  overflow
);

  localparam int ECW = $clog2(VECTOR_SIZE + 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ECW-1:0]        elem_cnt_q, elem_cnt_d;
  logic [CNT_WIDTH-1:0]  vec_count_q, vec_count_d;

`ifdef VECTOR_REDUCE_SAT_EN
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH:0]   sum;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    elem_cnt_d  = elem_cnt_q;
    vec_count_d = vec_count_q;
    in_rd_en    = 1'b0;
    out_wr_en   = 1'b0;
`ifdef VECTOR_REDUCE_SAT_EN
    ovf_d       = ovf_q;
    sum         = {1'b0, acc_q} + {1'b0, in_dout};
`endif
    unique case (state_q)
      S_ACC: begin
        in_rd_en = !in_empty;
        if (in_rd_en) begin
`ifdef VECTOR_REDUCE_SAT_EN
          // A carry pins the accumulator at all-ones for the rest of the vector.
          if (sum[DATA_WIDTH]) begin
            acc_d = {DATA_WIDTH{1'b1}};
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[DATA_WIDTH-1:0];
          end
`else
          acc_d = acc_q + in_dout;
`endif
          if (elem_cnt_q == ECW'(VECTOR_SIZE - 1)) begin
            elem_cnt_d = '0;
            state_d    = S_WRITE;
          end else begin
            elem_cnt_d = elem_cnt_q + ECW'(1);
          end
        end
      end
      S_WRITE: begin
        out_wr_en = !out_full;
        if (out_wr_en) begin
          acc_d       = '0;
          vec_count_d = vec_count_q + CNT_WIDTH'(1);
          state_d     = S_ACC;
`ifdef VECTOR_REDUCE_SAT_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      elem_cnt_q  <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      elem_cnt_q  <= elem_cnt_d;
      vec_count_q <= vec_count_d;
    end
  end

`ifdef VECTOR_REDUCE_SAT_EN
  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign out_din   = acc_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_vector_reduce.sv
// Directed bench for vector_reduce: table of whole-vector cases plus hand sequences for backpressure, back-to-back and mid-vector reset.
module tb_vector_reduce;
  import vector_reduce_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int VS = DEF_VECTOR_SIZE;
  localparam int CW = DEF_CNT_WIDTH;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_empty;
  logic          in_rd_en;
  logic [DW-1:0] in_dout;
  logic          out_full;
  logic          out_wr_en;
  logic [DW-1:0] out_din;
  logic [CW-1:0] vec_count;
  logic          overflow;

  vector_reduce #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .CNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .in_dout   (in_dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_din   (out_din),
    .vec_count (vec_count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int n_applied = 0;
  int n_mis     = 0;

  logic [DW-1:0] up_q[$];
  logic [DW-1:0] res_q[$];
  bit            res_ovf_q[$];
  int            cyc = 0;
  int            first_pop, last_pop, wr_cyc, n_pops;
  int            gap_pct = 0;
  bit            hold_full = 1'b0;
  bit            err_rd_empty = 1'b0;
  bit            err_both = 1'b0;
  logic [CW-1:0] exp_vc = '0;

  typedef struct {
    bit            ramp;
    logic [DW-1:0] val;
    int            gap;
    logic [DW-1:0] exp_res;
    bit            exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at negedge, let combinational outputs settle, then log what the next posedge will commit.
  task automatic step();
    @(negedge clock);
    in_empty = (up_q.size() == 0) || (gap_pct > 0 && $urandom_range(99) < gap_pct);
    in_dout  = (up_q.size() != 0) ? up_q[0] : 32'hDEAD_BEEF;
    out_full = hold_full;
    #1;
    if (in_rd_en && in_empty) err_rd_empty = 1'b1;
    if (in_rd_en && out_wr_en) err_both = 1'b1;
    if (in_rd_en && !reset) begin
      void'(up_q.pop_front());
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      n_pops++;
    end
    if (out_wr_en && !reset) begin
      res_q.push_back(out_din);
      res_ovf_q.push_back(overflow);
      wr_cyc = cyc;
      exp_vc = exp_vc + CW'(1);
    end
    cyc++;
  endtask

  task automatic clear_log();
    res_q.delete();
    res_ovf_q.delete();
    first_pop = -1;
    last_pop  = -1;
    wr_cyc    = -1;
    n_pops    = 0;
  endtask

  task automatic push_vec(input bit ramp, input logic [DW-1:0] val);
    for (int i = 0; i < VS; i++) up_q.push_back(ramp ? DW'(i + 1) : val);
  endtask

  task automatic run_until(input int nres, input int budget, input string name);
    int k = 0;
    while (res_q.size() < nres && k < budget) begin
      step();
      k++;
    end
    check({name, "_result_count"}, 64'(res_q.size()), 64'(nres));
  endtask

  vec_t tbl[6];

  initial begin
    logic [DW-1:0] ff_res;
    bit            ff_ovf;
    logic [DW-1:0] top_res;
    logic [DW-1:0] hold_din;
    bit            hold_ok;
`ifdef VECTOR_REDUCE_SAT_EN
    ff_res = 32'hFFFF_FFFF; ff_ovf = 1'b1; top_res = 32'hFFFF_FFFF;
`else
    ff_res = 32'hFFFF_FFC0; ff_ovf = 1'b0; top_res = 32'h0000_0000;
`endif
    tbl[0] = '{1'b1, 32'h0,         0,  32'h0000_0820, 1'b0};
    tbl[1] = '{1'b0, 32'hFFFF_FFFF, 0,  ff_res,        ff_ovf};
    tbl[2] = '{1'b1, 32'h0,         50, 32'h0000_0820, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0010, 0,  32'h0000_0400, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0000, 30, 32'h0000_0000, 1'b0};
    tbl[5] = '{1'b0, 32'h8000_0000, 0,  top_res,       ff_ovf};

    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;
    clear_log();
    repeat (3) step();
    check("reset_in_rd_en",  64'(in_rd_en),  64'd0);
    check("reset_out_wr_en", 64'(out_wr_en), 64'd0);
    check("reset_out_din",   64'(out_din),   64'd0);
    check("reset_vec_count", 64'(vec_count), 64'd0);
    check("reset_overflow",  64'(overflow),  64'd0);
    reset = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      clear_log();
      gap_pct = tbl[t].gap;
      push_vec(tbl[t].ramp, tbl[t].val);
      run_until(1, 2000, $sformatf("tbl%0d", t));
      if (res_q.size() != 0) begin
        check($sformatf("tbl%0d_out_din", t),  64'(res_q[0]),     64'(tbl[t].exp_res));
        check($sformatf("tbl%0d_ovf_wr", t),   64'(res_ovf_q[0]), 64'(tbl[t].exp_ovf));
      end
      check($sformatf("tbl%0d_pops", t),      64'(n_pops),            64'(VS));
      check($sformatf("tbl%0d_latency", t),   64'(wr_cyc - last_pop), 64'd1);
      if (tbl[t].gap == 0)
        check($sformatf("tbl%0d_span", t),    64'(wr_cyc - first_pop + 1), 64'(VS + 1));
      gap_pct = 0;
      step();
      check($sformatf("tbl%0d_vec_count", t), 64'(vec_count), 64'(exp_vc));
      check($sformatf("tbl%0d_ovf_after", t), 64'(overflow),  64'd0);
    end

    // Result FIFO full for 10 cycles on entering the write state, with the next vector already waiting.
    clear_log();
    push_vec(1'b1, '0);
    begin
      int k = 0;
      while (up_q.size() != 0 && k < 500) begin step(); k++; end
    end
    push_vec(1'b0, 32'h10);
    hold_full = 1'b1;
    hold_ok   = 1'b1;
    hold_din  = 32'h0000_0820;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_wr_en || in_rd_en || out_din !== hold_din) hold_ok = 1'b0;
    end
    check("hold_stable", 64'(hold_ok), 64'd1);
    check("hold_no_pops", 64'(up_q.size()), 64'(VS));
    hold_full = 1'b0;
    step();
    check("hold_write_cycle11", 64'(res_q.size()), 64'd1);
    run_until(2, 500, "hold_next");
    if (res_q.size() == 2) begin
      check("hold_res0", 64'(res_q[0]), 64'h820);
      check("hold_res1", 64'(res_q[1]), 64'h400);
    end

    // Two vectors queued back to back.
    clear_log();
    push_vec(1'b1, '0);
    push_vec(1'b0, 32'h10);
    run_until(2, 500, "b2b");
    repeat (5) step();
    check("b2b_no_extra", 64'(res_q.size()), 64'd2);
    if (res_q.size() == 2) begin
      check("b2b_res0", 64'(res_q[0]), 64'h820);
      check("b2b_res1", 64'(res_q[1]), 64'h400);
    end
    check("b2b_pops", 64'(n_pops), 64'(2 * VS));
    check("b2b_vec_count", 64'(vec_count), 64'(exp_vc));

    // Reset after 30 pops of a partial vector; the discarded words are not replayed.
    clear_log();
    push_vec(1'b0, 32'h1);
    begin
      int k = 0;
      while (n_pops < 30 && k < 200) begin step(); k++; end
    end
    check("rst_partial_pops", 64'(n_pops), 64'd30);
    up_q.delete();
    reset = 1'b1;
    repeat (2) step();
    check("rst_vec_count_zero", 64'(vec_count), 64'd0);
    reset  = 1'b0;
    exp_vc = '0;
    clear_log();
    push_vec(1'b0, 32'h2);
    run_until(1, 500, "rst");
    if (res_q.size() != 0) check("rst_res", 64'(res_q[0]), 64'h80);
    step();
    check("rst_vec_count", 64'(vec_count), 64'd1);

    check("never_rd_while_empty", 64'(err_rd_empty), 64'd0);
    check("never_rd_and_wr",      64'(err_both),     64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
    $finish;
  end

endmodule
